// File: rtl/instr_cycle_pkg.sv
// Shared state encoding for the instruction-cycle sequencer and its helpers.
package instr_cycle_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] START   = 3'd0;
  localparam logic [STATE_W-1:0] FETCH   = 3'd1;
  localparam logic [STATE_W-1:0] DECODE  = 3'd2;
  localparam logic [STATE_W-1:0] EXECUTE = 3'd3;
  localparam logic [STATE_W-1:0] HALT    = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_START   = START,
    ST_FETCH   = FETCH,
    ST_DECODE  = DECODE,
    ST_EXECUTE = EXECUTE,
    ST_HALT    = HALT
  } state_e;

endpackage

// File: rtl/instr_cycle_seq_if.sv
// Instruction-memory fetch port: request/address out, ack/data back.
interface instr_cycle_seq_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/exec_down_counter.sv
// Loadable down-counter with a zero flag; decrement saturates at zero.
module exec_down_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] count_r;

  // Count register: load has priority over decrement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/instr_cycle_seq.sv
// Fetch/decode/execute sequencer with PC, IR, variable-length execute,
// halt/resume and a retired-instruction counter.
module instr_cycle_seq
  import instr_cycle_pkg::*;
#(
  parameter int                AW       = 16,
  parameter int                DW       = 16,
  parameter int                OPW      = 4,
  parameter int                EXW      = 3,
  parameter logic [OPW-1:0]    HALT_OP  = 4'hF,
  parameter logic [AW-1:0]     RESET_PC = {AW{1'b0}},
  parameter int                CNTW     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 resume,
  input  logic [EXW-1:0]       exec_len,
  instr_cycle_seq_if.master    mem,
  output logic [DW-1:0]        ir,
  output logic [AW-1:0]        pc,
  output logic [STATE_W-1:0]   state,
  output logic                 exec_done,
  output logic                 halted,
  output logic [CNTW-1:0]      retired
);

  localparam logic [AW-1:0]   PC_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [EXW-1:0]  EX_ONE  = {{(EXW-1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  state_e          state_r;
  state_e          next_state_s;
  logic [AW-1:0]   pc_r;
  logic [DW-1:0]   ir_r;
  logic [CNTW-1:0] retired_r;

  logic            fetch_load_s;
  logic            retire_s;
  logic            ctr_load_s;
  logic [EXW-1:0]  ctr_load_val_s;
  logic            ctr_dec_s;
  logic [EXW-1:0]  ctr_count_s;
  logic            ctr_zero_s;
  logic [OPW-1:0]  opcode_s;

  assign opcode_s = ir_r[DW-1 -: OPW];

  exec_down_counter #(.W(EXW)) u_exec_ctr (
    .clock    (clock),
    .reset    (reset),
    .load     (ctr_load_s),
    .load_val (ctr_load_val_s),
    .dec      (ctr_dec_s),
    .count    (ctr_count_s),
    .zero     (ctr_zero_s)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_START;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    next_state_s   = state_r;
    fetch_load_s   = 1'b0;
    retire_s       = 1'b0;
    ctr_load_s     = 1'b0;
    ctr_dec_s      = 1'b0;
    // A zero length still needs one execute cycle.
    ctr_load_val_s = (exec_len == {EXW{1'b0}}) ? {EXW{1'b0}} : (exec_len - EX_ONE);
    case (state_r)
      ST_START: begin
        if (run) next_state_s = ST_FETCH;
        else     next_state_s = ST_START;
      end
      ST_FETCH: begin
        if (mem.mem_ack) begin
          fetch_load_s = 1'b1;
          next_state_s = ST_DECODE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (opcode_s == HALT_OP) begin
          retire_s     = 1'b1;
          next_state_s = ST_HALT;
        end else begin
          ctr_load_s   = 1'b1;
          next_state_s = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (!ctr_zero_s) begin
          ctr_dec_s    = 1'b1;
          next_state_s = ST_EXECUTE;
        end else begin
          retire_s     = 1'b1;
          next_state_s = run ? ST_FETCH : ST_START;
        end
      end
      ST_HALT: begin
        if (resume) next_state_s = ST_FETCH;
        else        next_state_s = ST_HALT;
      end
      default: next_state_s = ST_START;
    endcase
  end

  // PC and IR update on an acknowledged fetch.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r <= RESET_PC;
      ir_r <= {DW{1'b0}};
    end else if (fetch_load_s) begin
      pc_r <= pc_r + PC_ONE;
      ir_r <= mem.mem_rdata;
    end else begin
      pc_r <= pc_r;
      ir_r <= ir_r;
    end
  end

  // Retired-instruction counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_r <= {CNTW{1'b0}};
    end else if (retire_s) begin
      retired_r <= retired_r + CNT_ONE;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign mem.mem_req  = (state_r == ST_FETCH);
  assign mem.mem_addr = pc_r;
  assign ir           = ir_r;
  assign pc           = pc_r;
  assign state        = state_r;
  assign exec_done    = (state_r == ST_EXECUTE) && ctr_zero_s;
  assign halted       = (state_r == ST_HALT);
  assign retired      = retired_r;

endmodule

// File: tb/tb_instr_cycle_seq.sv
// Directed, table-driven bench for instr_cycle_seq plus hand-written corner sequences.
module tb_instr_cycle_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        resume = 1'b0;
  logic [2:0]  exec_len = 3'd0;
  logic        ack = 1'b0;
  logic [15:0] rdata = 16'h0000;

  logic [15:0] ir, pc, ir_w, pc_w;
  logic [2:0]  state, state_w;
  logic        exec_done, halted, exec_done_w, halted_w;
  logic [31:0] retired, retired_w;

  int n_checks = 0;
  int n_fail   = 0;

  instr_cycle_seq_if #(.AW(16), .DW(16)) bus ();
  instr_cycle_seq_if #(.AW(16), .DW(16)) bus_w ();

  assign bus.mem_ack     = ack;
  assign bus.mem_rdata   = rdata;
  assign bus_w.mem_ack   = ack;
  assign bus_w.mem_rdata = rdata;

  instr_cycle_seq dut (
    .clock(clock), .reset(reset), .run(run), .resume(resume), .exec_len(exec_len),
    .mem(bus), .ir(ir), .pc(pc), .state(state), .exec_done(exec_done),
    .halted(halted), .retired(retired)
  );

  // Second instance starting at the top of the address space to exercise pc wrap.
  instr_cycle_seq #(.RESET_PC(16'hFFFF)) dut_w (
    .clock(clock), .reset(reset), .run(run), .resume(resume), .exec_len(exec_len),
    .mem(bus_w), .ir(ir_w), .pc(pc_w), .state(state_w), .exec_done(exec_done_w),
    .halted(halted_w), .retired(retired_w)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        run;
    logic        resume;
    logic [2:0]  len;
    logic        ack;
    logic [15:0] rdata;
    logic [2:0]  st;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        done;
    logic        halt;
    logic [31:0] ret;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;

  task automatic add(input logic r, input logic rs, input logic [2:0] l, input logic a,
                     input logic [15:0] d, input logic [2:0] st, input logic [15:0] p,
                     input logic [15:0] i, input logic dn, input logic h, input logic [31:0] rt);
    vecs[nvec].run = r;   vecs[nvec].resume = rs; vecs[nvec].len = l;
    vecs[nvec].ack = a;   vecs[nvec].rdata = d;   vecs[nvec].st = st;
    vecs[nvec].pc = p;    vecs[nvec].ir = i;      vecs[nvec].done = dn;
    vecs[nvec].halt = h;  vecs[nvec].ret = rt;
    nvec++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [15:0] pcw_exp;

    // run rs len ack rdata   st pc      ir       dn h ret
    add(1, 0, 1, 0, 16'h0000, 1, 16'h0, 16'h0000, 0, 0, 0);
    add(1, 0, 1, 1, 16'h1001, 2, 16'h1, 16'h1001, 0, 0, 0);
    add(1, 0, 1, 1, 16'hBEEF, 3, 16'h1, 16'h1001, 1, 0, 0);
    add(1, 0, 1, 1, 16'hBEEF, 1, 16'h1, 16'h1001, 0, 0, 1);
    add(1, 0, 1, 1, 16'h2002, 2, 16'h2, 16'h2002, 0, 0, 1);
    add(1, 0, 1, 1, 16'hBEEF, 3, 16'h2, 16'h2002, 1, 0, 1);
    add(1, 0, 1, 1, 16'hBEEF, 1, 16'h2, 16'h2002, 0, 0, 2);
    add(1, 0, 1, 1, 16'h3003, 2, 16'h3, 16'h3003, 0, 0, 2);
    add(1, 0, 1, 1, 16'hBEEF, 3, 16'h3, 16'h3003, 1, 0, 2);
    add(1, 0, 1, 1, 16'hBEEF, 1, 16'h3, 16'h3003, 0, 0, 3);
    add(1, 0, 1, 1, 16'h4004, 2, 16'h4, 16'h4004, 0, 0, 3);
    add(1, 0, 1, 1, 16'hBEEF, 3, 16'h4, 16'h4004, 1, 0, 3);
    add(1, 0, 1, 1, 16'hBEEF, 1, 16'h4, 16'h4004, 0, 0, 4);
    // five-cycle execute
    add(1, 0, 5, 1, 16'h5005, 2, 16'h5, 16'h5005, 0, 0, 4);
    add(1, 0, 5, 1, 16'hBEEF, 3, 16'h5, 16'h5005, 0, 0, 4);
    add(1, 0, 5, 1, 16'hBEEF, 3, 16'h5, 16'h5005, 0, 0, 4);
    add(1, 0, 5, 1, 16'hBEEF, 3, 16'h5, 16'h5005, 0, 0, 4);
    add(1, 0, 5, 1, 16'hBEEF, 3, 16'h5, 16'h5005, 0, 0, 4);
    add(1, 0, 5, 1, 16'hBEEF, 3, 16'h5, 16'h5005, 1, 0, 4);
    add(1, 0, 5, 1, 16'hBEEF, 1, 16'h5, 16'h5005, 0, 0, 5);
    // exec_len = 0 behaves as 1
    add(1, 0, 0, 1, 16'h6006, 2, 16'h6, 16'h6006, 0, 0, 5);
    add(1, 0, 0, 1, 16'hBEEF, 3, 16'h6, 16'h6006, 1, 0, 5);
    add(1, 0, 0, 1, 16'hBEEF, 1, 16'h6, 16'h6006, 0, 0, 6);
    add(1, 0, 1, 1, 16'h7007, 2, 16'h7, 16'h7007, 0, 0, 6);
    add(1, 0, 1, 1, 16'hBEEF, 3, 16'h7, 16'h7007, 1, 0, 6);
    add(1, 0, 1, 1, 16'hBEEF, 1, 16'h7, 16'h7007, 0, 0, 7);
    // halt at pc 7, counted on entry
    add(1, 0, 3, 1, 16'hF000, 2, 16'h8, 16'hF000, 0, 0, 7);
    add(1, 0, 3, 1, 16'hBEEF, 4, 16'h8, 16'hF000, 0, 1, 8);
    for (int k = 0; k < 10; k++)
      add((k < 5) ? 1'b1 : 1'b0, 0, 1, 1, 16'hBEEF, 4, 16'h8, 16'hF000, 0, 1, 8);
    add(0, 1, 1, 1, 16'hBEEF, 1, 16'h8, 16'hF000, 0, 0, 8);
    add(1, 0, 1, 0, 16'hBEEF, 1, 16'h8, 16'hF000, 0, 0, 8);
    // run dropped during execute
    add(1, 0, 2, 1, 16'h9009, 2, 16'h9, 16'h9009, 0, 0, 8);
    add(1, 0, 2, 1, 16'hBEEF, 3, 16'h9, 16'h9009, 0, 0, 8);
    add(0, 0, 2, 1, 16'hBEEF, 3, 16'h9, 16'h9009, 1, 0, 8);
    add(0, 0, 2, 1, 16'hBEEF, 0, 16'h9, 16'h9009, 0, 0, 9);
    add(0, 0, 2, 1, 16'hBEEF, 0, 16'h9, 16'h9009, 0, 0, 9);
    add(1, 0, 1, 1, 16'hBEEF, 1, 16'h9, 16'h9009, 0, 0, 9);
    add(1, 0, 1, 1, 16'hA00A, 2, 16'hA, 16'hA00A, 0, 0, 9);
    add(1, 0, 1, 1, 16'hBEEF, 3, 16'hA, 16'hA00A, 1, 0, 9);
    add(1, 0, 1, 1, 16'hBEEF, 1, 16'hA, 16'hA00A, 0, 0, 10);

    // Reset state, checked while reset is held.
    #12;
    check("rst_state", state, 3'd0);
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_retired", retired, 32'd0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_exec_done", exec_done, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_w_pc", pc_w, 16'hFFFF);
    check("rst_w_state", state_w, 3'd0);
    check("rst_w_ir", ir_w, 16'h0000);
    check("rst_w_flags", {exec_done_w, halted_w, bus_w.mem_req}, 3'b000);
    #10;
    reset = 1'b1;

    for (int i = 0; i < nvec; i++) begin
      run = vecs[i].run; resume = vecs[i].resume; exec_len = vecs[i].len;
      ack = vecs[i].ack; rdata = vecs[i].rdata;
      cycle();
      pcw_exp = vecs[i].pc + 16'hFFFF;
      check($sformatf("v%0d_state", i), state, vecs[i].st);
      check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
      check($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].pc);
      check($sformatf("v%0d_ir", i), ir, vecs[i].ir);
      check($sformatf("v%0d_mem_req", i), bus.mem_req, (vecs[i].st == 3'd1) ? 1'b1 : 1'b0);
      check($sformatf("v%0d_exec_done", i), exec_done, vecs[i].done);
      check($sformatf("v%0d_halted", i), halted, vecs[i].halt);
      check($sformatf("v%0d_retired", i), retired, vecs[i].ret);
      check($sformatf("v%0d_w_state", i), state_w, vecs[i].st);
      check($sformatf("v%0d_w_pc", i), pc_w, pcw_exp);
      check($sformatf("v%0d_w_retired", i), retired_w, vecs[i].ret);
    end

    // Fetch wait states: three cycles without ack, address held.
    run = 1'b1; ack = 1'b0; rdata = 16'h1234; exec_len = 3'd1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("wait%0d_state", k), state, 3'd1);
      check($sformatf("wait%0d_mem_req", k), bus.mem_req, 1'b1);
      check($sformatf("wait%0d_mem_addr", k), bus.mem_addr, 16'h000A);
      check($sformatf("wait%0d_ir", k), ir, 16'hA00A);
    end
    ack = 1'b1;
    cycle();
    check("wait_ack_state", state, 3'd2);
    check("wait_ack_ir", ir, 16'h1234);
    check("wait_ack_pc", pc, 16'h000B);
    rdata = 16'hBEEF;
    cycle();
    check("wait_exec_done", exec_done, 1'b1);
    cycle();
    check("wait_back_fetch", state, 3'd1);
    check("wait_retired", retired, 32'd11);

    // Asynchronous reset between edges while fetching.
    ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_state", state, 3'd0);
    check("arst_mem_req", bus.mem_req, 1'b0);
    check("arst_pc", pc, 16'h0000);
    check("arst_retired", retired, 32'd0);
    check("arst_w_pc", pc_w, 16'hFFFF);
    ack = 1'b1; rdata = 16'h5555; run = 1'b1;
    cycle();
    check("arst_hold_ir", ir, 16'h0000);
    check("arst_hold_state", state, 3'd0);
    #3 reset = 1'b1;
    rdata = 16'h0F0F;
    cycle();
    check("post_rst_state", state, 3'd1);
    check("post_rst_pc", pc, 16'h0000);
    cycle();
    check("post_rst_ir", ir, 16'h0F0F);
    check("post_rst_pc_inc", pc, 16'h0001);
    check("wrap_pc", pc_w, 16'h0000);
    check("wrap_ir", ir_w, 16'h0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
